// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, state encodings and the IF/ID payload type for the fetch stage.
package if_fetch_unit_pkg;

    localparam logic enable_signal  = 1'b1;
    localparam logic disable_signal = 1'b0;

    localparam int inst_addr_bus_width = 32;
    localparam int InstBus             = 32;

    localparam logic [InstBus-1:0] zero_word = 32'h0000_0000;

    localparam logic [0:0] RST_HOLD = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    localparam logic [inst_addr_bus_width-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [inst_addr_bus_width-1:0] EXC_PC_DEFAULT   = 32'h0000_0020;

    typedef struct packed {
        logic [inst_addr_bus_width-1:0] pc;
        logic [InstBus-1:0]             inst;
        logic                           adel;
    } if_id_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush and bubble load zeros, stall_id holds, otherwise capture the fetch.
module if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           run_i,
    input  logic                           flush_i,
    input  logic                           stall_if_i,
    input  logic                           stall_id_i,
    input  logic [inst_addr_bus_width-1:0] pc_i,
    input  logic [InstBus-1:0]             inst_i,
    output logic [inst_addr_bus_width-1:0] id_pc_o,
    output logic [InstBus-1:0]             id_inst_o,
    output logic                           id_adel_o
);

    if_id_t id_q;
    if_id_t id_d;
    logic   misaligned;

    // A misaligned fetch still forwards its PC so the exception unit sees the bad address.
    always_comb begin
        misaligned = is_misaligned(pc_i[1:0]);
        id_d       = id_q;
        if (!run_i || flush_i || (stall_if_i && !stall_id_i)) begin
            id_d = '0;
        end else if (stall_id_i) begin
            id_d = id_q;
        end else begin
            id_d.pc   = pc_i;
            id_d.inst = misaligned ? zero_word : inst_i;
            id_d.adel = misaligned;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_pc_o   = id_q.pc;
    assign id_inst_o = id_q.inst;
    assign id_adel_o = id_q.adel;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation with flush/stall/pending-branch priority feeding the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic        ce_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_adel_o
);

    // EXC_PC is consumed by ctrl's new_pc mux; this block only refers to it here.
    if (EXC_PC[1:0] != 2'b00) begin : g_exc_pc_unaligned
    end

    logic [0:0]  state_q, state_d;
    logic        ce_q, ce_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // A branch seen while IF is stalled is parked and replayed on the first unstalled cycle.
    always_comb begin
        state_d       = state_q;
        ce_d          = ce_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (state_q == RST_HOLD) begin
            state_d = RUN;
            ce_d    = enable_signal;
        end else if (flush) begin
            pc_d         = new_pc;
            pend_valid_d = disable_signal;
        end else if (stall_if) begin
            if (branch_flag_i) begin
                pend_target_d = branch_target_address_i;
                pend_valid_d  = enable_signal;
            end
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = disable_signal;
        end else if (branch_flag_i) begin
            pc_d = branch_target_address_i;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RST_HOLD;
            ce_q          <= disable_signal;
            pc_q          <= RESET_PC;
            pend_valid_q  <= disable_signal;
            pend_target_q <= zero_word;
        end else begin
            state_q       <= state_d;
            ce_q          <= ce_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc_o = pc_q;
    assign ce_o = ce_q;

    if_id_reg u_if_id_reg (
        .clk_i      (clk),
        .rst_ni     (rst),
        .run_i      (state_q == RUN),
        .flush_i    (flush),
        .stall_if_i (stall_if),
        .stall_id_i (stall_id),
        .pc_i       (pc_q),
        .inst_i     (inst_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_adel_o  (id_adel_o)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: ROM model on pc_o, explicit PC expectations and an IF/ID scoreboard queue.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_adel_o;

    int     passed;
    int     total;
    if_id_t sb[$];
    if_id_t e;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    assign inst_i = rom(pc_o);

    if_fetch_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_if                (stall_if),
        .stall_id                (stall_id),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_i                  (inst_i),
        .pc_o                    (pc_o),
        .ce_o                    (ce_o),
        .id_pc_o                 (id_pc_o),
        .id_inst_o               (id_inst_o),
        .id_adel_o               (id_adel_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!(stall_id && !stall_if)) else $error("[TB] stall_id asserted without stall_if");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record what ID should see one cycle after pc_o=a is fetched.
    task automatic push_fetch(input logic [31:0] a);
        if_id_t t;
        t.pc   = a;
        t.adel = (a[1:0] != 2'b00);
        t.inst = t.adel ? 32'h0 : rom(a);
        sb.push_back(t);
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
        new_pc = 32'h0; branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({ce_o, pc_o} !== {1'b0, 32'h0}) $display("[TB] FAIL reset_ce_pc: got ce=%b pc=%h want ce=0 pc=00000000", ce_o, pc_o);
            else passed++;
            total++;
            if ({id_pc_o, id_inst_o, id_adel_o} !== 65'h0) $display("[TB] FAIL reset_id: got %h/%h/%b want zeros", id_pc_o, id_inst_o, id_adel_o);
            else passed++;
        end
        rst = 1'b1;
        step();
        total++;
        if ({ce_o, pc_o} !== {1'b1, 32'h0}) $display("[TB] FAIL release_ce_pc: got ce=%b pc=%h want ce=1 pc=00000000", ce_o, pc_o);
        else passed++;
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== 65'h0) $display("[TB] FAIL release_id: got %h/%h/%b want zeros", id_pc_o, id_inst_o, id_adel_o);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            push_fetch(32'(i * 4));
            step();
            total++;
            if (pc_o !== 32'((i + 1) * 4)) $display("[TB] FAIL first_fetch_pc: got %h want %h", pc_o, 32'((i + 1) * 4));
            else passed++;
            e = sb.pop_front();
            total++;
            if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL first_fetch_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
            else passed++;
        end
    endtask

    task automatic test_branch();
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        push_fetch(32'h8);
        step();
        branch_flag_i = 1'b0;
        total++;
        if (pc_o !== 32'h100) $display("[TB] FAIL branch_pc: got %h want 00000100", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL branch_delay_slot: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
        push_fetch(32'h100);
        step();
        total++;
        if (pc_o !== 32'h104) $display("[TB] FAIL branch_next_pc: got %h want 00000104", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL branch_target_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
    endtask

    task automatic test_branch_under_stall();
        stall_if = 1'b1; stall_id = 1'b1;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        for (int i = 0; i < 2; i++) begin
            step();
            branch_flag_i = 1'b0;
            total++;
            if (pc_o !== 32'h104) $display("[TB] FAIL stall_pc_hold: got %h want 00000104", pc_o);
            else passed++;
            total++;
            if ({id_pc_o, id_inst_o, id_adel_o} !== {32'h100, rom(32'h100), 1'b0}) $display("[TB] FAIL stall_id_hold: got %h/%h/%b want 00000100/%h/0", id_pc_o, id_inst_o, id_adel_o, rom(32'h100));
            else passed++;
        end
        stall_if = 1'b0; stall_id = 1'b0;
        push_fetch(32'h104);
        step();
        total++;
        if (pc_o !== 32'h200) $display("[TB] FAIL pending_redirect_pc: got %h want 00000200", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL pending_redirect_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
        push_fetch(32'h200);
        step();
        total++;
        if (pc_o !== 32'h204) $display("[TB] FAIL after_redirect_pc: got %h want 00000204", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL after_redirect_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
    endtask

    task automatic test_flush();
        stall_if = 1'b1; stall_id = 1'b1;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        step();
        total++;
        if ({pc_o, id_pc_o} !== {32'h204, 32'h200}) $display("[TB] FAIL flush_setup_hold: got pc=%h id_pc=%h want 00000204/00000200", pc_o, id_pc_o);
        else passed++;
        stall_if = 1'b0; stall_id = 1'b0;
        flush = 1'b1; new_pc = 32'h20;
        step();
        flush = 1'b0; branch_flag_i = 1'b0;
        total++;
        if (pc_o !== 32'h20) $display("[TB] FAIL flush_pc: got %h want 00000020", pc_o);
        else passed++;
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== 65'h0) $display("[TB] FAIL flush_id: got %h/%h/%b want zeros", id_pc_o, id_inst_o, id_adel_o);
        else passed++;
        push_fetch(32'h20);
        step();
        total++;
        if (pc_o !== 32'h24) $display("[TB] FAIL flush_pend_cleared: got %h want 00000024", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL flush_handler_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h102; exp_pc[1] = 32'h106; exp_pc[2] = 32'h10A; exp_pc[3] = 32'h40;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
        push_fetch(32'h24);
        for (int i = 0; i < 4; i++) begin
            branch_flag_i = (i == 0 || i == 3);
            branch_target_address_i = (i == 3) ? 32'h40 : 32'h102;
            if (i > 0) push_fetch(exp_pc[i - 1]);
            step();
            total++;
            if (pc_o !== exp_pc[i]) $display("[TB] FAIL misaligned_pc_%0d: got %h want %h", i, pc_o, exp_pc[i]);
            else passed++;
            e = sb.pop_front();
            total++;
            if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL misaligned_id_%0d: got %h/%h/%b want %h/%h/%b", i, id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
            else passed++;
        end
        branch_flag_i = 1'b0;
    endtask

    task automatic test_wrap_bubble();
        branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
        push_fetch(32'h40);
        step();
        branch_flag_i = 1'b0;
        total++;
        if (pc_o !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_setup_pc: got %h want fffffffc", pc_o);
        else passed++;
        e = sb.pop_front();
        push_fetch(32'hFFFF_FFFC);
        step();
        total++;
        if (pc_o !== 32'h0) $display("[TB] FAIL wrap_pc: got %h want 00000000", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL wrap_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
        stall_if = 1'b1;
        step();
        total++;
        if (pc_o !== 32'h0) $display("[TB] FAIL bubble_pc_hold: got %h want 00000000", pc_o);
        else passed++;
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== 65'h0) $display("[TB] FAIL bubble_id: got %h/%h/%b want zeros", id_pc_o, id_inst_o, id_adel_o);
        else passed++;
        stall_if = 1'b0;
        push_fetch(32'h0);
        step();
        total++;
        if (pc_o !== 32'h4) $display("[TB] FAIL bubble_resume_pc: got %h want 00000004", pc_o);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL bubble_resume_id: got %h/%h/%b want %h/%h/%b", id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic        br;
        logic [31:0] tgt;
        exp_pc = 32'h4;
        for (int i = 0; i < 12; i++) begin
            br  = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = 32'($urandom) & 32'h0000_FFFC;
            branch_flag_i = br; branch_target_address_i = tgt;
            push_fetch(exp_pc);
            step();
            exp_pc = br ? tgt : exp_pc + 32'd4;
            total++;
            if (pc_o !== exp_pc) $display("[TB] FAIL b2b_pc_%0d: got %h want %h", i, pc_o, exp_pc);
            else passed++;
            e = sb.pop_front();
            total++;
            if ({id_pc_o, id_inst_o, id_adel_o} !== e) $display("[TB] FAIL b2b_id_%0d: got %h/%h/%b want %h/%h/%b", i, id_pc_o, id_inst_o, id_adel_o, e.pc, e.inst, e.adel);
            else passed++;
        end
        branch_flag_i = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_branch();
        test_branch_under_stall();
        test_flush();
        test_misaligned();
        test_wrap_bubble();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Generates the fetch PC and ROM chip-enable, and applies branch redirects and exception flushes.
- Captures the ROM's combinational instruction word into the IF/ID pipeline register consumed by the decode stage.
- Handles pipeline stalls: a branch arriving while IF is stalled is held pending, never lost.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- EXC_PC, 32'h0000_0020, reserved for the ctrl block's new_pc computation; not used internally.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- stall_if  input  1  hold PC (from ctrl).
- stall_id  input  1  hold IF/ID register (from ctrl).
- flush  input  1  exception flush (from ctrl).
- new_pc  input  32  exception handler address, valid with flush.
- branch_flag_i  input  1  taken branch/jump from ID.
- branch_target_address_i  input  32  branch target, valid with branch_flag_i.
- inst_i  input  32  instruction word from ROM, combinational on pc_o.
- pc_o  output  32  fetch address to ROM addr.
- ce_o  output  1  ROM chip-enable.
- id_pc_o  output  32  PC of instruction presented to ID.
- id_inst_o  output  32  instruction presented to ID.
- id_adel_o  output  1  fetch address-error flag accompanying id_inst_o.

Behaviour:
- State machine: RST_HOLD -> RUN.
  - While rst=0: state <= RST_HOLD, ce_o <= 0, pc_o <= RESET_PC, pend_valid <= 0, id_pc_o <= 0, id_inst_o <= 0, id_adel_o <= 0.
  - First cycle after rst=1: state <= RUN, ce_o <= 1; pc_o stays RESET_PC, so the first fetch is RESET_PC.
  - ce_o stays 1 in RUN.
- PC update in RUN, priority highest first:
  1. flush: pc_o <= new_pc; pend_valid <= 0; any branch in the same cycle is discarded.
  2. stall_if=1: pc_o holds. If branch_flag_i=1, latch pend_target <= branch_target_address_i and set pend_valid <= 1.
  3. pend_valid=1: pc_o <= pend_target; pend_valid <= 0. This takes precedence over a new branch_flag_i in the same cycle; ID cannot issue a second branch before the first redirect.
  4. branch_flag_i=1: pc_o <= branch_target_address_i.
  5. Otherwise: pc_o <= pc_o + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Misaligned address: pc_o[1:0] != 0 is "misaligned".
  - The IF/ID register captures id_inst_o <= 0 and id_adel_o <= 1, and still loads id_pc_o <= pc_o so the exception unit receives the bad address.
  - pc_o still advances normally; ctrl is expected to flush.
- IF/ID register, evaluated every cycle in RUN, priority highest first:
  1. flush: id_pc_o <= 0, id_inst_o <= 0, id_adel_o <= 0.
  2. stall_if=1 and stall_id=0: insert bubble (same zero values).
  3. stall_id=1: hold all id_* outputs.
  4. Otherwise: id_pc_o <= pc_o, id_inst_o <= inst_i (or 0 if misaligned), id_adel_o <= misaligned.
- In RST_HOLD the IF/ID register loads zeros: no instruction is issued while ce_o was 0.
- stall_id=1 with stall_if=0 is illegal from ctrl; the block holds IF/ID and advances PC. The bench checks via an assertion that this never occurs.
- Latency: the instruction at address A appears on id_inst_o one clock after pc_o=A with no stalls.
- Branch delay slot: the instruction following the branch is fetched naturally. The redirect applies one cycle after branch_flag_i, so the delay slot is never squashed by this block.

Decomposition:
- Shared defines header holds the constants:
  - enable_signal / disable_signal
  - zero_word
  - inst_addr_bus_width, InstBus
  - the RUN / RST_HOLD state encodings
  - RESET_PC and EXC_PC defaults
- One natural sub-module: if_id_reg, the IF/ID pipeline register with flush/bubble/hold logic. PC generation stays in the top module.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then release. Expect ce_o=0 during reset; ce_o=1 the cycle after release; pc_o sequence 0, 0, 4, 8; id_inst_o = mem[0] at the first clock edge where pc_o=4.
- Branch: branch_flag_i=1, target 32'h0000_0100 while pc_o=8. Expect next pc_o=0x100; delay slot (pc 8) still reaches ID; then id_pc_o=0x100.
- Branch under stall: stall_if=stall_id=1 for 2 cycles, with branch_flag_i=1 (target 0x200) in the first stalled cycle only. Expect pc_o held throughout the stall, id_* outputs held, and the first unstalled cycle loading pc_o=0x200.
- Flush with simultaneous branch: flush=1, new_pc=0x20, branch_flag_i=1 (target 0x300), pend_valid set. Expect pc_o=0x20, pend_valid cleared, and id_inst_o=0 for one cycle.
- Misaligned target 0x102: expect id_adel_o=1, id_pc_o=0x102, id_inst_o=0; then pc_o=0x106 if no flush follows.
- Wrap and bubble:
  - Force pc_o=32'hFFFF_FFFC: expect next pc_o=0.
  - stall_if=1, stall_id=0: expect id_inst_o=0 and id_pc_o=0 for that cycle.
